// File: rtl/twiddle_mult_pipe.sv
// Pipelined complex twiddle multiplier: unity path for the leading samples of each
// frame, programmable coefficient with optional conjugation for the other samples.
module twiddle_mult_pipe #(
    parameter int NBITS      = 12,
    parameter int NBITScoeff = 11,
    parameter int NBITS_out  = NBITS + NBITScoeff + 1,
    parameter int PERIOD     = 8,
    parameter int NTRIV      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*NBITS-1:0]        muestra,
    input  logic                      in_valid,
    input  logic                      sync,
    input  logic                      conj,
    input  logic [2*NBITScoeff-1:0]   coeff_in,
    input  logic                      coeff_load,
    output logic [2*NBITS_out-1:0]    result,
    output logic                      out_valid,
    output logic                      out_trivial
);

    localparam int IDX_W  = $clog2(PERIOD);
    localparam int PROD_W = NBITS + NBITScoeff;
    localparam int SHL_W  = NBITS + NBITScoeff - 2;
    localparam logic [IDX_W:0] NTRIV_L = (IDX_W + 1)'(NTRIV);
    localparam logic signed [NBITScoeff-1:0] UNITY = NBITScoeff'(1 << (NBITScoeff - 2));

    function automatic logic signed [PROD_W-1:0] smul(
        input logic signed [NBITS-1:0]      d,
        input logic signed [NBITScoeff-1:0] c
    );
        logic signed [PROD_W-1:0] de;
        logic signed [PROD_W-1:0] ce;
        de = PROD_W'(d);
        ce = PROD_W'(c);
        return de * ce;
    endfunction

    function automatic logic signed [NBITS_out-1:0] sx_out(
        input logic signed [PROD_W-1:0] p
    );
        return NBITS_out'(p);
    endfunction

    // Unity multiply is a pure left shift by the coefficient's fractional bits.
    function automatic logic signed [NBITS_out-1:0] unity_out(
        input logic signed [NBITS-1:0] d
    );
        logic signed [SHL_W-1:0] t;
        t = {d, {(NBITScoeff - 2){1'b0}}};
        return NBITS_out'(t);
    endfunction

    logic signed [NBITS-1:0]      mr_in;
    logic signed [NBITS-1:0]      mi_in;
    logic [IDX_W-1:0]             idx_q;
    logic [IDX_W-1:0]             cur_idx;
    logic [IDX_W-1:0]             next_idx;
    logic                         triv_in;
    logic signed [NBITScoeff-1:0] cr_q;
    logic signed [NBITScoeff-1:0] ci_q;

    logic signed [NBITS-1:0]      mr_p0;
    logic signed [NBITS-1:0]      mi_p0;
    logic signed [NBITScoeff-1:0] cr_p0;
    logic signed [NBITScoeff-1:0] ci_p0;
    logic                         conj_p0;
    logic                         triv_p0;
    logic                         vld_p0;

    logic signed [PROD_W-1:0]     rr_p1;
    logic signed [PROD_W-1:0]     ii_p1;
    logic signed [PROD_W-1:0]     ri_p1;
    logic signed [PROD_W-1:0]     ir_p1;
    logic signed [NBITS-1:0]      mr_p1;
    logic signed [NBITS-1:0]      mi_p1;
    logic                         conj_p1;
    logic                         triv_p1;
    logic                         vld_p1;

    logic signed [NBITS_out-1:0]  re_nxt;
    logic signed [NBITS_out-1:0]  im_nxt;
    logic signed [NBITS_out-1:0]  re_p2;
    logic signed [NBITS_out-1:0]  im_p2;
    logic                         triv_p2;
    logic                         vld_p2;

    assign mr_in = muestra[2*NBITS-1:NBITS];
    assign mi_in = muestra[NBITS-1:0];

    // A sync sample is index 0 regardless of where the counter was.
    always_comb begin
        cur_idx  = sync ? '0 : idx_q;
        next_idx = cur_idx + IDX_W'(1);
        triv_in  = ({1'b0, cur_idx} < NTRIV_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            cr_q    <= UNITY;
            ci_q    <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            triv_p2 <= 1'b0;
            re_p2   <= '0;
            im_p2   <= '0;
        end else begin
            if (in_valid) begin
                idx_q <= next_idx;
            end else if (sync) begin
                idx_q <= '0;
            end
            if (coeff_load) begin
                cr_q <= coeff_in[2*NBITScoeff-1:NBITScoeff];
                ci_q <= coeff_in[NBITScoeff-1:0];
            end
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                re_p2   <= re_nxt;
                im_p2   <= im_nxt;
                triv_p2 <= triv_p1;
            end
        end
    end

    // Stage 1: capture sample, current coefficient and per-sample flags
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mr_p0   <= mr_in;
            mi_p0   <= mi_in;
            cr_p0   <= cr_q;
            ci_p0   <= ci_q;
            conj_p0 <= conj;
            triv_p0 <= triv_in;
        end
    end

    // Stage 2: four partial products at full width
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            rr_p1   <= smul(mr_p0, cr_p0);
            ii_p1   <= smul(mi_p0, ci_p0);
            ri_p1   <= smul(mr_p0, ci_p0);
            ir_p1   <= smul(mi_p0, cr_p0);
            mr_p1   <= mr_p0;
            mi_p1   <= mi_p0;
            conj_p1 <= conj_p0;
            triv_p1 <= triv_p0;
        end
    end

    // Stage 3: combine products; conjugation flips signs of the ci terms, never ci itself
    always_comb begin
        re_nxt = '0;
        im_nxt = '0;
        if (triv_p1) begin
            re_nxt = unity_out(mr_p1);
            im_nxt = unity_out(mi_p1);
        end else if (conj_p1) begin
            re_nxt = sx_out(rr_p1) + sx_out(ii_p1);
            im_nxt = sx_out(ir_p1) - sx_out(ri_p1);
        end else begin
            re_nxt = sx_out(rr_p1) - sx_out(ii_p1);
            im_nxt = sx_out(ri_p1) + sx_out(ir_p1);
        end
    end

    assign result      = {re_p2, im_p2};
    assign out_valid   = vld_p2;
    assign out_trivial = triv_p2;

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Scoreboard bench for twiddle_mult_pipe: directed vectors with hand-computed
// products, checked by an independent output monitor.
module tb_twiddle_mult_pipe;

    localparam int NO = 24;

    logic        clk;
    logic        rst;
    logic [23:0] muestra;
    logic        in_valid;
    logic        sync;
    logic        conj;
    logic [21:0] coeff_in;
    logic        coeff_load;
    logic [47:0] result;
    logic        out_valid;
    logic        out_trivial;

    twiddle_mult_pipe #(
        .NBITS(12), .NBITScoeff(11), .NBITS_out(24), .PERIOD(8), .NTRIV(3)
    ) dut (
        .clk(clk), .rst(rst), .muestra(muestra), .in_valid(in_valid),
        .sync(sync), .conj(conj), .coeff_in(coeff_in), .coeff_load(coeff_load),
        .result(result), .out_valid(out_valid), .out_trivial(out_trivial)
    );

    typedef struct {
        logic signed [NO-1:0] re;
        logic signed [NO-1:0] im;
        logic                 triv;
        int                   due;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic signed [NO-1:0] last_re = '0;
    logic signed [NO-1:0] last_im = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic signed [47:0] act,
                                  input logic signed [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Output monitor: pops one expectation per valid output; otherwise result must hold.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got out_valid=1, expected no output");
                end else begin
                    e = sb.pop_front();
                    check("result_re", $signed(result[47:24]), e.re);
                    check("result_im", $signed(result[23:0]), e.im);
                    check("out_trivial", out_trivial, e.triv);
                    check("latency_cycle", cyc, e.due);
                    last_re = e.re;
                    last_im = e.im;
                end
            end else begin
                check("hold_re", $signed(result[47:24]), last_re);
                check("hold_im", $signed(result[23:0]), last_im);
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic c,
                         input int r, input int i, input int er, input int ei,
                         input logic et, input logic ld = 1'b0,
                         input int lcr = 0, input int lci = 0);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid   = v;
        sync       = s;
        conj       = c;
        muestra    = {12'(r), 12'(i)};
        coeff_load = ld;
        coeff_in   = {11'(lcr), 11'(lci)};
        if (v) begin
            e.re   = 24'(er);
            e.im   = 24'(ei);
            e.triv = et;
            e.due  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic s = 1'b0);
        drive(1'b0, s, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic load(input int cr, input int ci);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1, cr, ci);
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle();
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #1;
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic reset_dut();
        drain();
        @(negedge clk);
        #1 rst = 1'b1;
        last_re = '0;
        last_im = '0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; sync = 1'b0; conj = 1'b0;
        muestra = '0; coeff_in = '0; coeff_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_out_trivial", out_trivial, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Plain frame: indices 0-2 unity, 3-7 coefficient {362,-363}
        load(362, -363);
        for (int k = 0; k < 8; k++) begin
            if (k < 3) drive(1'b1, k == 0, 1'b0, 100, -50, 51200, -25600, 1'b1);
            else       drive(1'b1, k == 0, 1'b0, 100, -50, 18050, -54400, 1'b0);
        end

        // Same frame, conjugate on index 3 only
        for (int k = 0; k < 8; k++) begin
            if (k < 3)       drive(1'b1, k == 0, 1'b0, 100, -50, 51200, -25600, 1'b1);
            else if (k == 3) drive(1'b1, 1'b0, 1'b1, 100, -50, 54350, 18200, 1'b0);
            else             drive(1'b1, 1'b0, 1'b0, 100, -50, 18050, -54400, 1'b0);
        end
        drain();

        // Load coincident with index 4: index 4 still sees unity
        reset_dut();
        idle(1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k < 3)      drive(1'b1, 1'b0, 1'b0, 100, -50, 51200, -25600, 1'b1);
            else if (k < 5) drive(1'b1, 1'b0, 1'b0, 100, -50, 51200, -25600, 1'b0,
                                  k == 4, 362, -363);
            else            drive(1'b1, 1'b0, 1'b0, 100, -50, 18050, -54400, 1'b0);
        end
        drain();

        // Extremes: mr=mi=-2048, cr=ci=-1024
        load(-1024, -1024);
        drive(1'b1, 1'b1, 1'b0, -2048, -2048, -1048576, -1048576, 1'b1);
        drive(1'b1, 1'b0, 1'b0, -2048, -2048, -1048576, -1048576, 1'b1);
        drive(1'b1, 1'b0, 1'b0, -2048, -2048, -1048576, -1048576, 1'b1);
        drive(1'b1, 1'b0, 1'b0, -2048, -2048, 0, 4194304, 1'b0);
        drive(1'b1, 1'b0, 1'b1, -2048, -2048, 4194304, 0, 1'b0);

        // Bubble pattern 1,0,1,1 with mid-frame sync on the third sample
        load(362, -363);
        drive(1'b1, 1'b0, 1'b0, 100, -50, 18050, -54400, 1'b0);
        idle();
        drive(1'b1, 1'b1, 1'b0, 100, -50, 51200, -25600, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 100, -50, 51200, -25600, 1'b1);
        drain();

        // Reset with three samples in flight (indices 2,3,4)
        drive(1'b1, 1'b0, 1'b0, 100, -50, 51200, -25600, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 100, -50, 18050, -54400, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 100, -50, 18050, -54400, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_result", result, 0);
        check("async_rst_out_trivial", out_trivial, 0);
        sb.delete();
        last_re = '0;
        last_im = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 100, -50, 51200, -25600, k < 3);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
